scoreboard_register_file: RTL and testbench
===========================================

Name: scoreboard_register_file

Overview:
- Parametrised successor to the single-cycle 8x16 register file, for the pipelined core.
- Two read ports and one write port, with write-to-read bypass and optional registered reads.
- Per-register pending-write counters (scoreboard) let decode detect RAW hazards and stall.
- Sits between decode (reads, reservations) and writeback (writes).
- Register 0 is hardwired to zero. Operand muxing (imm, lui, pc+1) moves out to a decode-stage block.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of architectural registers (power of two, >=2).
- ADDR_W, $clog2(NUM_REGS), register index width.
- PEND_W, 2, pending-counter width per register; max outstanding writes per register is 2**PEND_W-1.
- READ_REG, 0, 0 = combinational read data; 1 = read data registered (1-cycle latency).
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr_a  in  ADDR_W  read port A index.
- rd_addr_b  in  ADDR_W  read port B index.
- rd_data_a  out  DATA_W  read port A data.
- rd_data_b  out  DATA_W  read port B data.
- busy_a  out  1  pending count of rd_addr_a is nonzero.
- busy_b  out  1  pending count of rd_addr_b is nonzero.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback index.
- wr_data  in  DATA_W  writeback data.
- rsv_en  in  1  reserve destination (instruction issued).
- rsv_addr  in  ADDR_W  destination to reserve.
- rsv_ready  out  1  reservation would be accepted this cycle.
- flush  in  1  clear all pending counters (pipeline squash).

Behaviour:
- Reset (rst=1 at a clk edge):
  - All registers, all pending counters and registered read outputs go to 0.
  - rsv_ready=1 after reset.
  - rst overrides wr_en, rsv_en and flush in the same cycle.
- Write:
  - When wr_en=1 and wr_addr!=0, mem[wr_addr] takes wr_data at the edge.
  - Writes to index 0 are dropped; mem[0] is always 0.
- Read, READ_REG=0:
  - rd_data_x = (rd_addr_x==0) ? 0 : (BYPASS && wr_en && wr_addr==rd_addr_x) ? wr_data : mem[rd_addr_x].
- Read, READ_REG=1:
  - Same expression is registered; data appears one cycle after the address.
- busy_x:
  - Combinational, from the current counter value (pre-edge), qualified with rd_addr_x!=0.
  - When BYPASS=1, a same-cycle wr_en to the same address whose count is exactly 1 clears busy_x, because that data is forwarded.
  - busy is not registered, even with READ_REG=1.
- Pending counters, per register, next-state priority:
  - flush: all counters become 0. Any same-cycle rsv is also discarded; the register write itself still happens.
  - Else, for register r:
    - inc = rsv_en && rsv_addr==r && r!=0 && rsv_ready.
    - dec = wr_en && wr_addr==r && cnt[r]!=0.
    - inc && dec: unchanged.
    - inc only: +1.
    - dec only: -1.
  - A write to a register with count 0 is legal (untracked write). The counter stays 0, with no underflow.
- rsv_ready:
  - Low only when rsv_addr!=0, cnt[rsv_addr]==max, and there is no same-cycle decrementing write to rsv_addr.
  - A reservation made while rsv_ready=0 is ignored; the requester holds rsv_en and rsv_addr.
  - Reserving index 0 is always accepted and has no effect.
- Simultaneous read/write to the same address with BYPASS=0: old value read (write-first is not applied).
- Outputs are fully defined for every address, so there are no X-propagation paths.

Decomposition:
- Shared package holds DATA_W, NUM_REGS, ADDR_W defaults and the opcode localparams (add, addi, nand, lui, sw, lw, beq, jalr).
- Decode muxing uses these opcodes; this block does not.
- One natural sub-module: pending_counter. It owns one PEND_W-bit saturating up/down counter with inc/dec/clr and exposes nonzero and full.
- The top instantiates NUM_REGS-1 of these in a generate loop; r0 has none.

Test Plan:
- Reset then read all indices -> rd_data_a/b = 0x0000, busy_a/b = 0, rsv_ready = 1.
- Write r3=0x1234 while reading rd_addr_a=3, BYPASS=1, READ_REG=0 -> rd_data_a = 0x1234 the same cycle; with BYPASS=0 -> 0x0000 that cycle, then 0x1234 the next.
- Write r0=0xFFFF, then read r0 -> 0x0000. Reserve r0 -> rsv_ready=1 and busy stays 0.
- Reserve r5 three times (PEND_W=2) -> busy_a=1 for rd_addr_a=5. A fourth reserve gives rsv_ready=0 and the count stays 3. The same fourth reserve together with wr_en to r5 is accepted and the count stays 3. Three more writes -> busy_a=0.
- Reserve r2 twice, then assert flush together with rsv r2 and a write r2=0x00AA -> next cycle busy=0 for r2, mem[2]=0x00AA, count=0.
- READ_REG=1: write r7=0xBEEF, then present rd_addr_b=7 -> rd_data_b = 0xBEEF exactly one cycle later. Assert rst mid-stream -> rd_data_b = 0 and all counters 0 on the next edge.

Source files
------------

// File: rtl/scoreboard_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_register_file_pkg
// Purpose  : Shared defaults for the register file geometry and the core's
//            opcode encodings. The opcodes are consumed by the decode-stage
//            operand mux; the register file itself does not decode them.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package scoreboard_register_file_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
   localparam int DEF_PEND_W   = 2;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

endpackage
`default_nettype wire

// File: rtl/scoreboard_register_file_pending_counter.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_register_file_pending_counter
// Purpose  : Saturating up/down counter of outstanding writes to one register.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            clr              - clear to zero (pipeline flush)
//            inc, dec         - reservation / retiring write; both = hold
//            count            - current count
//            nonzero, full    - count != 0, count == all-ones
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_register_file_pending_counter #(
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   input  logic              dec,
   output logic [PEND_W-1:0] count,
   output logic              nonzero,
   output logic              full
);

   assign nonzero = |count;
   assign full    = &count;

   // Saturation guards keep the counter from wrapping even if a caller
   // presents an inc on a full counter or a dec on an empty one.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + PEND_W'(1);
      end else if (dec && !inc && nonzero) begin
         count <= count - PEND_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/scoreboard_register_file.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_register_file
// Purpose  : 2R/1W register file with write-to-read bypass, optional
//            registered reads and a per-register pending-write scoreboard.
// Ports    : clk, rst                      - clock, sync active-high reset
//            rd_addr_a/b, rd_data_a/b      - read ports
//            busy_a/b                      - read register has pending writes
//            wr_en, wr_addr, wr_data       - writeback port
//            rsv_en, rsv_addr, rsv_ready   - destination reservation
//            flush                         - clear all pending counters
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_register_file
   import scoreboard_register_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int PEND_W   = DEF_PEND_W,
   parameter int READ_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              busy_a,
   output logic              busy_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ready,
   input  logic              flush
);

   logic [DATA_W-1:0] mem [NUM_REGS];
   logic [PEND_W-1:0] cnt [NUM_REGS];
   logic [NUM_REGS-1:0] nz;
   logic [NUM_REGS-1:0] fl;
   logic [DATA_W-1:0] rd_raw_a;
   logic [DATA_W-1:0] rd_raw_b;

   // ---------------------------------------------------------------------
   // Storage. Entry 0 is cleared by reset and never written afterwards.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   function automatic logic [DATA_W-1:0] read_of(input logic [ADDR_W-1:0] a);
      if (a == '0)
         return '0;
      else if ((BYPASS != 0) && wr_en && (wr_addr == a))
         return wr_data;
      else
         return mem[a];
   endfunction

   // A register whose only outstanding write is retiring this cycle is not
   // busy when bypass is on: the reader picks the value off the write port.
   function automatic logic busy_of(input logic [ADDR_W-1:0] a);
      return (a != '0) && nz[a] &&
             !((BYPASS != 0) && wr_en && (wr_addr == a) && (cnt[a] == PEND_W'(1)));
   endfunction

   assign rd_raw_a = read_of(rd_addr_a);
   assign rd_raw_b = read_of(rd_addr_b);
   assign busy_a   = busy_of(rd_addr_a);
   assign busy_b   = busy_of(rd_addr_b);

   generate
      if (READ_REG != 0) begin : g_read_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data_a <= '0;
               rd_data_b <= '0;
            end else begin
               rd_data_a <= rd_raw_a;
               rd_data_b <= rd_raw_b;
            end
         end
      end else begin : g_read_comb
         assign rd_data_a = rd_raw_a;
         assign rd_data_b = rd_raw_b;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Scoreboard. A write retiring on a full register frees a slot in the
   // same cycle, so a reservation paired with it nets to no change.
   // ---------------------------------------------------------------------
   assign rsv_ready = !((rsv_addr != '0) && fl[rsv_addr] &&
                        !(wr_en && (wr_addr == rsv_addr)));

   assign nz[0]  = 1'b0;
   assign fl[0]  = 1'b0;
   assign cnt[0] = '0;

   generate
      for (genvar r = 1; r < NUM_REGS; r++) begin : g_pending
         logic inc;
         logic dec;

         assign inc = rsv_en && (rsv_addr == ADDR_W'(r)) && rsv_ready;
         assign dec = wr_en && (wr_addr == ADDR_W'(r)) && nz[r];

         scoreboard_register_file_pending_counter #(
            .PEND_W (PEND_W)
         ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clr     (flush),
            .inc     (inc),
            .dec     (dec),
            .count   (cnt[r]),
            .nonzero (nz[r]),
            .full    (fl[r])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_scoreboard_register_file
// Purpose  : Directed, table-driven bench. Three instances share stimulus:
//            u_byp (BYPASS=1, comb read), u_nob (BYPASS=0, comb read) and
//            u_reg (BYPASS=1, registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scoreboard_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
   logic        wr_en, rsv_en, flush;
   logic [15:0] wr_data;

   logic [15:0] a0, b0, a1, b1, a2, b2;
   logic        ba0, bb0, ba1, bb1, ba2, bb2;
   logic        rdy0, rdy1, rdy2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   scoreboard_register_file #(.READ_REG(0), .BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(a0), .rd_data_b(b0), .busy_a(ba0), .busy_b(bb0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rdy0), .flush(flush));

   scoreboard_register_file #(.READ_REG(0), .BYPASS(0)) u_nob (
      .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(a1), .rd_data_b(b1), .busy_a(ba1), .busy_b(bb1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rdy1), .flush(flush));

   scoreboard_register_file #(.READ_REG(1), .BYPASS(1)) u_reg (
      .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(a2), .rd_data_b(b2), .busy_a(ba2), .busy_b(bb2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rdy2), .flush(flush));

   typedef struct {
      logic [2:0]  ra, rb;
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        rv;
      logic [2:0]  rva;
      logic        fl;
      logic [15:0] ea, eb;      // bypass instance read data
      logic        eba, ebb;    // bypass instance busy
      logic        erdy;        // rsv_ready (same for all)
      logic [15:0] ea_nb;       // no-bypass instance rd_data_a
      logic        eba_nb;      // no-bypass instance busy_a
   } vec_t;

   vec_t vt [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] ra, input logic [2:0] rb,
                        input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic rv, input logic [2:0] rva, input logic fl);
      rd_addr_a = ra; rd_addr_b = rb;
      wr_en = we; wr_addr = wa; wr_data = wd;
      rsv_en = rv; rsv_addr = rva; flush = fl;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] prev_a;

      //         ra rb we wa wd       rv rva fl  ea       eb       eba ebb rdy ea_nb    eba_nb
      vt[0]  = '{0, 7, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 0};
      vt[1]  = '{3, 1, 1, 3, 16'h1234, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 1, 16'h0000, 0};
      vt[2]  = '{3, 0, 1, 0, 16'hFFFF, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 1, 16'h1234, 0};
      vt[3]  = '{0, 3, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h1234, 0, 0, 1, 16'h0000, 0};
      vt[4]  = '{5, 0, 0, 0, 16'h0000, 1, 5, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 0};
      vt[5]  = '{5, 0, 0, 0, 16'h0000, 1, 5, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0000, 1};
      vt[6]  = '{5, 0, 0, 0, 16'h0000, 1, 5, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0000, 1};
      vt[7]  = '{5, 0, 0, 0, 16'h0000, 1, 5, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 1};
      vt[8]  = '{5, 0, 0, 0, 16'h0000, 1, 5, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 1};
      vt[9]  = '{5, 0, 1, 5, 16'h0055, 1, 5, 0, 16'h0055, 16'h0000, 1, 0, 1, 16'h0000, 1};
      vt[10] = '{5, 0, 1, 5, 16'h0056, 0, 0, 0, 16'h0056, 16'h0000, 1, 0, 1, 16'h0055, 1};
      vt[11] = '{5, 0, 1, 5, 16'h0057, 0, 0, 0, 16'h0057, 16'h0000, 1, 0, 1, 16'h0056, 1};
      vt[12] = '{5, 5, 1, 5, 16'h0058, 0, 0, 0, 16'h0058, 16'h0058, 0, 0, 1, 16'h0057, 1};
      vt[13] = '{5, 5, 0, 0, 16'h0000, 0, 0, 0, 16'h0058, 16'h0058, 0, 0, 1, 16'h0058, 0};
      vt[14] = '{4, 0, 1, 4, 16'h4444, 0, 0, 0, 16'h4444, 16'h0000, 0, 0, 1, 16'h0000, 0};
      vt[15] = '{4, 0, 0, 0, 16'h0000, 1, 2, 0, 16'h4444, 16'h0000, 0, 0, 1, 16'h4444, 0};
      vt[16] = '{2, 0, 0, 0, 16'h0000, 1, 2, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0000, 1};
      vt[17] = '{2, 0, 1, 2, 16'h00AA, 1, 2, 1, 16'h00AA, 16'h0000, 1, 0, 1, 16'h0000, 1};
      vt[18] = '{2, 4, 0, 0, 16'h0000, 0, 0, 0, 16'h00AA, 16'h4444, 0, 0, 1, 16'h00AA, 0};
      vt[19] = '{2, 0, 0, 0, 16'h0000, 1, 2, 0, 16'h00AA, 16'h0000, 0, 0, 1, 16'h00AA, 0};

      rst = 1'b1;
      drive(0, 0, 0, 0, 16'h0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Table: inputs applied just after an edge, outputs sampled mid-cycle.
      prev_a = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         drive(vt[i].ra, vt[i].rb, vt[i].we, vt[i].wa, vt[i].wd,
               vt[i].rv, vt[i].rva, vt[i].fl);
         #3;
         chk($sformatf("v%0d rd_a", i),      a0,   vt[i].ea);
         chk($sformatf("v%0d rd_b", i),      b0,   vt[i].eb);
         chk($sformatf("v%0d busy_a", i),    ba0,  vt[i].eba);
         chk($sformatf("v%0d busy_b", i),    bb0,  vt[i].ebb);
         chk($sformatf("v%0d rdy", i),       rdy0, vt[i].erdy);
         chk($sformatf("v%0d nb rd_a", i),   a1,   vt[i].ea_nb);
         chk($sformatf("v%0d nb busy_a", i), ba1,  vt[i].eba_nb);
         chk($sformatf("v%0d reg rd_a", i),  a2,   prev_a);
         chk($sformatf("v%0d reg busy_a", i), ba2, vt[i].eba);
         prev_a = vt[i].ea;
         next_cycle();
      end

      // Registered read latency and mid-stream reset.
      drive(0, 3, 1, 7, 16'hBEEF, 0, 0, 0);
      next_cycle();
      drive(0, 7, 0, 0, 16'h0000, 1, 6, 0);
      #3;
      chk("reg rd_b before latency", b2, 16'h1234);
      chk("comb rd_b r7",            b0, 16'hBEEF);
      next_cycle();
      drive(0, 7, 0, 0, 16'h0000, 1, 6, 0);
      #3;
      chk("reg rd_b r7 one cycle later", b2, 16'hBEEF);
      next_cycle();
      rst = 1'b1;
      drive(6, 7, 1, 7, 16'h1111, 1, 6, 0);
      #3;
      chk("busy_a r6 before reset", ba0, 1'b1);
      next_cycle();
      rst = 1'b0;
      drive(6, 7, 0, 0, 16'h0000, 0, 0, 0);
      #3;
      chk("reg rd_b after reset",  b2,   16'h0000);
      chk("comb rd_b after reset", b0,   16'h0000);
      chk("busy_a r6 after reset", ba0,  1'b0);
      chk("rdy after reset",       rdy0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
